spi_psram_target: RTL and testbench

//  SPI mode-0 target that answers the PSRAM command set which the PSRAM controller's SPI master issues.
//  A byte-addressed internal RAM backs the read and write commands.
//  The block is fully synchronous to PCLK. SCLK, MCS and MOSI are oversampled; there is no SCLK clock domain.
//  It serves as the FPGA/sim stand-in for the external PSRAM in the peripheral subsystem.

---
 rtl/spi_psram_target_pkg.sv | 22 ++
 rtl/spi_psram_target_if.sv | 13 +
 rtl/spi_psram_target_in_sync.sv | 49 ++++
 rtl/spi_psram_target.sv | 215 +++++++++++++++++++++
 tb/tb_spi_psram_target.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_psram_target_pkg.sv
// rtl/spi_psram_target_pkg.sv - PSRAM opcodes and FSM state encoding.
package spi_psram_target_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_RSTEN = 8'h66;
  localparam logic [7:0] OP_RST   = 8'h99;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_ID,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_psram_target_if.sv
// rtl/spi_psram_target_if.sv - SPI bus between PSRAM master and target.
interface spi_psram_target_if;

  logic sclk;
  logic mcs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output mcs, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input mcs, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_psram_target_in_sync.sv
// rtl/spi_psram_target_in_sync.sv - SPI input synchronizer with SCLK/MCS edge detection.
module spi_psram_target_in_sync #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic mcs,
  input  logic mosi,
  output logic mcs_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_N-1:0] sclk_q;
  logic [SYNC_N-1:0] mcs_q;
  logic [SYNC_N-1:0] mosi_q;
  logic              sclk_d;
  logic              mcs_d;

  // MCS resets to "selected" so a frame already in progress at reset
  // never produces a falling edge; only a genuine high-then-low does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mcs_q  <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      mcs_d  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_N-2:0], sclk};
      mcs_q  <= {mcs_q[SYNC_N-2:0], mcs};
      mosi_q <= {mosi_q[SYNC_N-2:0], mosi};
      sclk_d <= sclk_q[SYNC_N-1];
      mcs_d  <= mcs_q[SYNC_N-1];
    end
  end

  assign mcs_s     = mcs_q[SYNC_N-1];
  assign mosi_s    = mosi_q[SYNC_N-1];
  assign sclk_rise = sclk_q[SYNC_N-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_N-1] & sclk_d;
  assign cs_fall   = ~mcs_s & mcs_d;
  assign cs_rise   = mcs_s & ~mcs_d;

endmodule

// File: rtl/spi_psram_target.sv
// rtl/spi_psram_target.sv - SPI mode-0 PSRAM target with internal RAM; FAST_READ_EN adds opcode 0x0B.
module spi_psram_target
  import spi_psram_target_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter int          SYNC_N = 2,
  parameter logic [7:0]  ID_MFR = 8'h0D,
  parameter logic [7:0]  ID_KGD = 8'h5D
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_psram_target_if.slave  spi,
  output logic               busy,
  output logic               cmd_err,
  output logic               soft_rst
);

  logic mcs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic rise, fall;

  spi_psram_target_in_sync #(.SYNC_N(SYNC_N)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (spi.sclk),
    .mcs       (spi.mcs),
    .mosi      (spi.mosi),
    .mcs_s     (mcs_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  assign rise = sclk_rise & ~mcs_s;
  assign fall = sclk_fall & ~mcs_s;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [4:0]        addr_cnt;
  logic [6:0]        sh_in;
  logic [7:0]        op;
  logic [7:0]        tx_sh;
  logic [ADDR_W-1:0] addr;
  logic              rst_armed, load_pend, id_kgd_next, live;

  logic [7:0]        ram [2**ADDR_W];
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;

  logic [ADDR_W-1:0] addr_in;
  logic [7:0]        byte_in;
  logic              last_bit, last_addr;

  assign addr_in   = {addr[ADDR_W-2:0], mosi_s};
  assign byte_in   = {sh_in, mosi_s};
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_addr = (addr_cnt == 5'd23);

  // Prefetch address: the freshly completed address while in ADDR, else the next byte.
  always_comb begin
    rd_addr = addr + ADDR_W'(1);
    if (state == ST_ADDR) rd_addr = addr_in;
    wr_en = (state == ST_WDATA) && rise && last_bit;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[addr] <= byte_in;
    rd_data <= ram[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      addr_cnt    <= 5'd0;
      sh_in       <= 7'd0;
      op          <= 8'd0;
      tx_sh       <= 8'd0;
      addr        <= '0;
      rst_armed   <= 1'b0;
      load_pend   <= 1'b0;
      id_kgd_next <= 1'b0;
      live        <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      soft_rst    <= 1'b0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
    end else begin
      cmd_err   <= 1'b0;
      soft_rst  <= 1'b0;
      load_pend <= 1'b0;
      live      <= live | cs_rise;
      busy      <= live & ~mcs_s;
      if (load_pend) tx_sh <= rd_data;

      if (mcs_s) begin
        state       <= ST_IDLE;
        bit_cnt     <= 3'd0;
        addr_cnt    <= 5'd0;
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state <= ST_CMD;
              if (rise) begin
                sh_in   <= {6'd0, mosi_s};
                bit_cnt <= 3'd1;
              end
            end
          end
          ST_CMD: begin
            if (rise) begin
              sh_in   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                op        <= byte_in;
                rst_armed <= (byte_in == OP_RSTEN);
                addr_cnt  <= 5'd0;
                case (byte_in)
                  OP_READ, OP_WRITE, OP_RDID: state <= ST_ADDR;
`ifdef FAST_READ_EN
                  OP_FREAD: state <= ST_ADDR;
`else
                  OP_FREAD: begin
                    cmd_err <= 1'b1;
                    state   <= ST_IGNORE;
                  end
`endif
                  OP_RSTEN: state <= ST_IGNORE;
                  OP_RST: begin
                    soft_rst <= rst_armed;
                    state    <= ST_IGNORE;
                  end
                  default: begin
                    cmd_err <= 1'b1;
                    state   <= ST_IGNORE;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              addr     <= addr_in;
              addr_cnt <= addr_cnt + 5'd1;
              if (last_addr) begin
                addr_cnt <= 5'd0;
                bit_cnt  <= 3'd0;
                case (op)
                  OP_WRITE: state <= ST_WDATA;
                  OP_RDID: begin
                    state       <= ST_ID;
                    tx_sh       <= ID_MFR;
                    id_kgd_next <= 1'b1;
                    spi.miso_oe <= 1'b1;
                  end
`ifdef FAST_READ_EN
                  OP_FREAD: begin
                    state     <= ST_DUMMY;
                    load_pend <= 1'b1;
                  end
`endif
                  default: begin
                    state       <= ST_RDATA;
                    load_pend   <= 1'b1;
                    spi.miso_oe <= 1'b1;
                  end
                endcase
              end
            end
          end
          ST_DUMMY: begin
            if (rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                state       <= ST_RDATA;
                spi.miso_oe <= 1'b1;
              end
            end
          end
          ST_RDATA, ST_ID: begin
            if (fall) begin
              spi.miso <= tx_sh[7];
              tx_sh    <= {tx_sh[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (state == ST_ID) begin
                  tx_sh       <= id_kgd_next ? ID_KGD : ID_MFR;
                  id_kgd_next <= ~id_kgd_next;
                end else begin
                  addr      <= addr + ADDR_W'(1);
                  load_pend <= 1'b1;
                end
              end
            end
          end
          ST_WDATA: begin
            if (rise) begin
              sh_in   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) addr <= addr + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_psram_target.sv
// tb/tb_spi_psram_target.sv - Directed self-checking bench for spi_psram_target.
module tb_spi_psram_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, cmd_err, soft_rst;

  spi_psram_target_if spi();

  spi_psram_target dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (spi),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .soft_rst (soft_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cmd_err_cnt = 0;
  int soft_rst_cnt = 0;
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (cmd_err === 1'b1) cmd_err_cnt++;
    if (soft_rst === 1'b1) soft_rst_cnt++;
    if (spi.miso_oe === 1'b1) oe_cnt++;
  end

  // SCLK half period is 8 PCLK cycles; MISO is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.mosi = tx[i];
      #80;
      rx[i] = spi.miso;
      spi.sclk = 1'b1;
      #80;
      spi.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi.mosi = 1'b0;
    spi.mcs  = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    spi.mcs = 1'b1;
    #160;
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    xfer(op, 8, d);
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  task automatic wr2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] d;
    cs_low();
    hdr(8'h02, a);
    xfer(b0, 8, d);
    xfer(b1, 8, d);
    cs_high();
  endtask

  task automatic rd2(input logic [23:0] a, output logic [7:0] r0, output logic [7:0] r1);
    cs_low();
    hdr(8'h03, a);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    cs_high();
  endtask

  task automatic test_reset();
    spi.sclk = 1'b0;
    spi.mcs  = 1'b1;
    spi.mosi = 1'b0;
    rst_n    = 1'b0;
    #52;
    rst_n = 1'b1;
    #100;
    n_checks++; if (spi.miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", spi.miso); end
    n_checks++; if (spi.miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b expected 0", spi.miso_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    n_checks++; if (soft_rst !== 1'b0) begin n_fail++; $display("FAIL reset_soft_rst: got %b expected 0", soft_rst); end
  endtask

  task automatic test_write_read();
    logic [7:0] d, r0, r1;
    logic oe_mid;
    cs_low();
    hdr(8'h02, 24'h000010);
    xfer(8'hAA, 8, d);
    xfer(8'h55, 8, d);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_in_frame: got %b expected 1", busy); end
    cs_high();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after: got %b expected 0", busy); end
    cs_low();
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, r0);
    oe_mid = spi.miso_oe;
    xfer(8'h00, 8, r1);
    cs_high();
    n_checks++; if (r0 !== 8'hAA) begin n_fail++; $display("FAIL rd_byte0: got %h expected aa", r0); end
    n_checks++; if (r1 !== 8'h55) begin n_fail++; $display("FAIL rd_byte1: got %h expected 55", r1); end
    n_checks++; if (oe_mid !== 1'b1) begin n_fail++; $display("FAIL rd_miso_oe: got %b expected 1", oe_mid); end
    n_checks++; if (spi.miso_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_after_cs: got %b expected 0", spi.miso_oe); end
  endtask

  task automatic test_wrap();
    logic [7:0] r0, r1, z0, z1;
    wr2(24'h0003FF, 8'h11, 8'h22);
    rd2(24'h0003FF, r0, r1);
    rd2(24'h000000, z0, z1);
    n_checks++; if (r0 !== 8'h11) begin n_fail++; $display("FAIL wrap_byte0: got %h expected 11", r0); end
    n_checks++; if (r1 !== 8'h22) begin n_fail++; $display("FAIL wrap_byte1: got %h expected 22", r1); end
    n_checks++; if (z0 !== 8'h22) begin n_fail++; $display("FAIL wrap_ram0: got %h expected 22", z0); end
  endtask

  task automatic test_read_id();
    logic [7:0] r0, r1, r2;
    cs_low();
    hdr(8'h9F, 24'h000000);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    xfer(8'h00, 8, r2);
    cs_high();
    n_checks++; if (r0 !== 8'h0D) begin n_fail++; $display("FAIL id_byte0: got %h expected 0d", r0); end
    n_checks++; if (r1 !== 8'h5D) begin n_fail++; $display("FAIL id_byte1: got %h expected 5d", r1); end
    n_checks++; if (r2 !== 8'h0D) begin n_fail++; $display("FAIL id_byte2: got %h expected 0d", r2); end
  endtask

  task automatic test_soft_reset();
    logic [7:0] d;
    int s0, e0;
    s0 = soft_rst_cnt;
    e0 = cmd_err_cnt;
    cs_low(); xfer(8'h66, 8, d); cs_high();
    cs_low(); xfer(8'h99, 8, d); cs_high();
    n_checks++; if (soft_rst_cnt - s0 !== 1) begin n_fail++; $display("FAIL soft_rst_seq: got %0d pulses expected 1", soft_rst_cnt - s0); end
    n_checks++; if (cmd_err_cnt - e0 !== 0) begin n_fail++; $display("FAIL soft_rst_no_err: got %0d pulses expected 0", cmd_err_cnt - e0); end
    s0 = soft_rst_cnt;
    cs_low(); xfer(8'h99, 8, d); cs_high();
    n_checks++; if (soft_rst_cnt - s0 !== 0) begin n_fail++; $display("FAIL soft_rst_alone: got %0d pulses expected 0", soft_rst_cnt - s0); end
  endtask

  task automatic test_partial_byte();
    logic [7:0] d, r0, r1;
    wr2(24'h000021, 8'h77, 8'h88);
    cs_low();
    hdr(8'h02, 24'h000020);
    xfer(8'hC3, 8, d);
    xfer(8'hF0, 4, d);
    cs_high();
    rd2(24'h000020, r0, r1);
    n_checks++; if (r0 !== 8'hC3) begin n_fail++; $display("FAIL partial_ram20: got %h expected c3", r0); end
    n_checks++; if (r1 !== 8'h77) begin n_fail++; $display("FAIL partial_ram21: got %h expected 77", r1); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] d;
    int e0, o0;
    e0 = cmd_err_cnt;
    o0 = oe_cnt;
    cs_low();
    xfer(8'h5A, 8, d);
    xfer(8'h00, 8, d);
    xfer(8'h00, 8, d);
    cs_high();
    n_checks++; if (cmd_err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_op_cmd_err: got %0d pulses expected 1", cmd_err_cnt - e0); end
    n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL bad_op_miso_oe: got %0d cycles expected 0", oe_cnt - o0); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d, r0, r1;
    int o0;
    cs_low();
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 4, d);
    n_checks++; if (spi.miso_oe !== 1'b1) begin n_fail++; $display("FAIL arst_oe_before: got %b expected 1", spi.miso_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (spi.miso_oe !== 1'b0) begin n_fail++; $display("FAIL arst_oe_in_reset: got %b expected 0", spi.miso_oe); end
    #21;
    rst_n = 1'b1;
    o0 = oe_cnt;
    xfer(8'h00, 8, d);
    xfer(8'h00, 8, d);
    n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL arst_dead_frame: got %0d oe cycles expected 0", oe_cnt - o0); end
    cs_high();
    rd2(24'h000010, r0, r1);
    n_checks++; if (r0 !== 8'hAA) begin n_fail++; $display("FAIL arst_next_byte0: got %h expected aa", r0); end
    n_checks++; if (r1 !== 8'h55) begin n_fail++; $display("FAIL arst_next_byte1: got %h expected 55", r1); end
  endtask

  task automatic test_fast_read();
    logic [7:0] d;
`ifdef FAST_READ_EN
    logic [7:0] r0;
    cs_low();
    hdr(8'h0B, 24'h000010);
    xfer(8'h00, 8, d);
    xfer(8'h00, 8, r0);
    cs_high();
    n_checks++; if (r0 !== 8'hAA) begin n_fail++; $display("FAIL fast_read_byte0: got %h expected aa", r0); end
`else
    int e0, o0;
    e0 = cmd_err_cnt;
    o0 = oe_cnt;
    cs_low();
    hdr(8'h0B, 24'h000010);
    xfer(8'h00, 8, d);
    cs_high();
    n_checks++; if (cmd_err_cnt - e0 !== 1) begin n_fail++; $display("FAIL fast_read_cmd_err: got %0d pulses expected 1", cmd_err_cnt - e0); end
    n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL fast_read_oe: got %0d cycles expected 0", oe_cnt - o0); end
`endif
  endtask

  initial begin
    spi.sclk = 1'b0;
    spi.mcs  = 1'b1;
    spi.mosi = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_wrap();
    test_read_id();
    test_soft_reset();
    test_partial_byte();
    test_bad_opcode();
    test_async_reset();
    test_fast_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
